// File: rtl/bcd2bin.sv
// bcd2bin -- 4-digit packed BCD to 14-bit binary converter.
//
// Sequential reverse double-dabble: the {digit, result} pair is shifted
// right one bit per cycle, and every digit nibble that reaches 8 or more
// after the shift has 3 subtracted so that it keeps behaving as decimal.
// A conversion takes 14 CONV cycles, and the result is then held in DONE
// until the consumer takes it.
//
// Optional feature: define BCD2BIN_DIGIT_CHECK_EN to reject inputs that
// have a nibble greater than 9. Such an input is reported with out_err=1
// and bin_out=0 one cycle after the transfer. Without the macro, out_err
// is tied to 0 and every input runs the full 14-step algorithm.
//
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous, active-high reset
//   in_valid  bcd_in holds a value to convert
//   in_ready  block can accept a value (IDLE only)
//   bcd_in    four BCD digits, [15:12] = thousands, [3:0] = units
//   out_valid bin_out/out_err hold a result (DONE)
//   out_ready consumer takes the result
//   bin_out   binary result 0..9999
//   out_err   an input digit was greater than 9
//   busy      state is not IDLE
module bcd2bin (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] bcd_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [13:0] bin_out,
   output logic        out_err,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [15:0] dig;
   logic [13:0] res;

   logic [29:0] shifted;
   logic [15:0] next_dig;
   logic [13:0] next_res;

   // One conversion step. The correction after the last shift is skipped:
   // it could only touch the digit register, which is empty by then.
   always_comb begin
      shifted  = {dig, res} >> 1;
      next_dig = shifted[29:14];
      next_res = shifted[13:0];
      if (cnt != 4'd13) begin
         for (int i = 0; i < 4; i++) begin
            if (next_dig[i*4 +: 4] >= 4'd8)
               next_dig[i*4 +: 4] = next_dig[i*4 +: 4] - 4'd3;
         end
      end
   end

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic err;
   logic bad;

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bcd_in[i*4 +: 4] > 4'd9) bad = 1'b1;
      end
   end

   // An invalid input passes through CONV for one cycle without shifting,
   // so the error result is presented after the edge following the transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         dig   <= '0;
         res   <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               dig   <= bcd_in;
               res   <= '0;
               cnt   <= '0;
               err   <= bad;
               state <= CONV;
            end
            CONV: if (err) begin
               state <= DONE;
            end else begin
               dig <= next_dig;
               res <= next_res;
               cnt <= cnt + 4'd1;
               if (cnt == 4'd13) state <= DONE;
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign out_err = err;
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         dig   <= '0;
         res   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               dig   <= bcd_in;
               res   <= '0;
               cnt   <= '0;
               state <= CONV;
            end
            CONV: begin
               dig <= next_dig;
               res <= next_res;
               cnt <= cnt + 4'd1;
               if (cnt == 4'd13) state <= DONE;
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign out_err = 1'b0;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign bin_out   = res;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: a vector table run through a driver
// that pushes expected results to a scoreboard queue, a monitor that pops
// and compares on each result hand-off, plus hand-written sequences for
// output back-pressure, reset abort and back-to-back transfers.
module tb_bcd2bin;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] bcd_in;
   logic        out_valid;
   logic        out_ready;
   logic [13:0] bin_out;
   logic        out_err;
   logic        busy;

   bcd2bin dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready),
      .bin_out(bin_out), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bcd;
      logic [13:0] bin;
      logic        err;
      logic        chk_bin;
      int          lat;
   } vec_t;

   typedef struct {
      logic [13:0] bin;
      logic        err;
      logic        chk_bin;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_pop = 0;
   int   n_xfer = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard side: compare every handed-off result with the oldest
   // expectation.
   always @(negedge clk) begin
      if (!reset && in_valid && in_ready) n_xfer++;
      if (!reset && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got bin=%0d, expected none", bin_out);
         end else begin
            exp_t e;
            e = q.pop_front();
            n_pop++;
            if (e.chk_bin) chk("bin_out", int'(bin_out), int'(e.bin));
            chk("out_err", int'(out_err), int'(e.err));
         end
      end
   end

   // Wait for the block to accept; returns after the transfer edge (+1).
   task automatic wait_xfer(input string name, output int waited);
      waited = 0;
      while (1) begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 60) begin
            chk({name, "_xfer_timeout"}, 0, 1);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   // Counts edges after the transfer until out_valid is seen.
   task automatic wait_valid(input string name, output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) chk({name, "_valid_timeout"}, 0, 1);
   endtask

   task automatic run(input vec_t v);
      int w, lat;
      q.push_back('{bin: v.bin, err: v.err, chk_bin: v.chk_bin});
      bcd_in   = v.bcd;
      in_valid = 1'b1;
      wait_xfer("run", w);
      in_valid = 1'b0;
      chk("busy_after_xfer", int'(busy), 1);
      wait_valid("run", lat);
      chk("latency", lat, v.lat);
      @(posedge clk); #1;   // hand-off edge (out_ready=1)
      chk("out_valid_after_handoff", int'(out_valid), 0);
   endtask

   vec_t tbl[$];

   initial begin
      int w, lat, t;
      vec_t v;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bcd_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_bin_out", int'(bin_out), 0);
      chk("rst_out_err", int'(out_err), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      tbl.push_back('{16'h1234, 14'd1234, 1'b0, 1'b1, 14});
      tbl.push_back('{16'h9999, 14'd9999, 1'b0, 1'b1, 14});
      tbl.push_back('{16'h0000, 14'd0,    1'b0, 1'b1, 14});
      tbl.push_back('{16'h0001, 14'd1,    1'b0, 1'b1, 14});
      tbl.push_back('{16'h1000, 14'd1000, 1'b0, 1'b1, 14});
      tbl.push_back('{16'h8888, 14'd8888, 1'b0, 1'b1, 14});
      tbl.push_back('{16'h0809, 14'd809,  1'b0, 1'b1, 14});
      tbl.push_back('{16'h5678, 14'd5678, 1'b0, 1'b1, 14});
`ifdef BCD2BIN_DIGIT_CHECK_EN
      tbl.push_back('{16'h12A4, 14'd0, 1'b1, 1'b1, 1});
      tbl.push_back('{16'hF000, 14'd0, 1'b1, 1'b1, 1});
`else
      tbl.push_back('{16'h12A4, 14'd0, 1'b0, 1'b0, 14});
`endif
      tbl.push_back('{16'h0042, 14'd42, 1'b0, 1'b1, 14});

      foreach (tbl[i]) run(tbl[i]);

      // Back-pressure: result must hold while out_ready is low.
      out_ready = 1'b0;
      q.push_back('{bin: 14'd500, err: 1'b0, chk_bin: 1'b1});
      bcd_in = 16'h0500; in_valid = 1'b1;
      wait_xfer("hold", w);
      in_valid = 1'b0;
      wait_valid("hold", lat);
      chk("hold_latency", lat, 14);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         chk("hold_bin_out", int'(bin_out), 500);
         chk("hold_out_valid", int'(out_valid), 1);
         chk("hold_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_released", int'(out_valid), 0);
      chk("hold_in_ready_after", int'(in_ready), 1);

      // Reset in the middle of a conversion discards it.
      bcd_in = 16'h4321; in_valid = 1'b1;
      wait_xfer("abort", w);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_bin_out", int'(bin_out), 0);
      chk("abort_out_err", int'(out_err), 0);
      @(posedge clk); #1 reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (out_valid) chk("abort_no_stale_result", int'(out_valid), 0);
      end
      chk("abort_idle", int'(busy), 0);
      v = '{16'h0042, 14'd42, 1'b0, 1'b1, 14};
      run(v);

      // in_valid held high across two values: exactly two transfers,
      // 16 cycles apart.
      n_xfer = 0;
      q.push_back('{bin: 14'd1, err: 1'b0, chk_bin: 1'b1});
      q.push_back('{bin: 14'd2, err: 1'b0, chk_bin: 1'b1});
      bcd_in = 16'h0001; in_valid = 1'b1;
      wait_xfer("b2b_a", w);
      bcd_in = 16'h0002;
      t = 0;
      while (1) begin
         @(negedge clk);
         t++;
         if (in_ready || t > 60) break;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_spacing", t, 16);
      wait_valid("b2b_b", lat);
      chk("b2b_latency", lat, 14);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_transfers", n_xfer, 2);

      chk("scoreboard_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bcd2bin.md
BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 The module SHALL have no parameters; the width is fixed at 4 BCD digits in and 14 binary bits out.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  bcd_in holds a value to convert.
REQ-005 in_ready  output  1  block can accept a value.
REQ-006 bcd_in  input  16  four packed BCD digits; [15:12] is thousands, [3:0] is units.
REQ-007 out_valid  output  1  bin_out and out_err hold a result.
REQ-008 out_ready  input  1  consumer takes the result.
REQ-009 bin_out  output  14  unsigned binary result, 0..9999.
REQ-010 out_err  output  1  an input digit was greater than 9 (see Configuration).
REQ-011 busy  output  1  state is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, CONV, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; a transfer occurs on an edge where in_valid=1 and in_ready=1.
REQ-014 On a transfer, the block SHALL load bcd_in into a 16-bit digit register, clear the 14-bit result register, clear the step counter, and enter CONV.
REQ-015 Each CONV cycle SHALL perform one step: shift {digit reg, result reg} (30 bits) right by one, then subtract 3 from every digit nibble whose value is 8 or more.
REQ-016 The subtract-3 correction SHALL be applied on steps 1 to 13 and SHALL be skipped on step 14.
REQ-017 After the 14th step, the FSM SHALL enter DONE with out_valid=1.
REQ-018 Latency: with the transfer at edge E0, out_valid SHALL be 1 after edge E14, exactly 14 cycles later.
REQ-019 In DONE, bin_out and out_err SHALL hold stable until an edge with out_ready=1.
REQ-020 On the edge where out_ready=1 in DONE, the FSM SHALL return to IDLE and out_valid SHALL go to 0.
REQ-021 A new transfer SHALL NOT be accepted in the same cycle as a result hand-off; the minimum spacing between transfers is 16 cycles.
REQ-022 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-023 For valid BCD inputs, bin_out SHALL equal the decimal value of the input, and the digit register SHALL be zero at DONE.

Reset
REQ-024 While reset=1, the state SHALL be IDLE, and the counter, digit register and result register SHALL be 0.
REQ-025 During reset, outputs SHALL be in_ready=1, out_valid=0, busy=0, bin_out=0, out_err=0.
REQ-026 Reset asserted in CONV or DONE SHALL abort the operation immediately; the pending result SHALL be discarded and not presented after reset.

Configuration
REQ-027 The feature SHALL be controlled by the macro BCD2BIN_DIGIT_CHECK_EN.
REQ-028 When the macro is defined: at transfer, if any nibble of bcd_in exceeds 9, the block SHALL skip CONV and go to DONE after E1, with out_err=1 and bin_out=0.
REQ-029 When the macro is defined and all nibbles are 9 or less, the block SHALL set out_err=0 and use normal timing.
REQ-030 When the macro is not defined: out_err SHALL be constant 0, and every input SHALL take the full 14-step path, returning the deterministic algorithm output.

Verification
REQ-031 bcd_in=16'h1234 -> out_valid rises 14 cycles after transfer, bin_out=14'd1234, out_err=0.
REQ-032 bcd_in=16'h9999 and then 16'h0000 -> bin_out=14'd9999, then bin_out=14'd0.
REQ-033 bcd_in=16'h0500, out_ready held 0 for 20 cycles after DONE -> bin_out=14'd500 stable, in_ready=0 throughout; hand-off on the first out_ready=1 edge.
REQ-034 reset pulsed 5 cycles after a 16'h4321 transfer -> all outputs at reset values; a following 16'h0042 gives bin_out=14'd42.
REQ-035 With BCD2BIN_DIGIT_CHECK_EN: bcd_in=16'h12A4 -> out_valid one cycle after transfer, out_err=1, bin_out=0. Without the macro: out_err=0 after 14 cycles.
REQ-036 Hold in_valid=1 across 16'h0001 and 16'h0002 -> exactly two transfers, 16 cycles apart, with results 1 then 2.
